pri_arb_rr: RTL and testbench
=============================

Name: pri_arb_rr

Overview:
- Parametrised, registered N-input priority arbiter with selectable fixed-priority or round-robin mode.
- Grants one requester at a time and holds the grant while that requester keeps its request asserted.
- A hold-timeout counter forces re-arbitration so no requester starves.
- Sits in front of shared resources (bus, output port) and gives clean one-hot plus encoded grant outputs.

Parameters:
- N, 8, number of requesters (N >= 2); higher index = higher fixed priority.
- IDX_W, $clog2(N), width of encoded grant index (derived, not overridden).
- MAX_HOLD, 16, max consecutive grant cycles before forced re-arbitration; 0 disables timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbiter enable; low forces no grant.
- mode  input  1  0 = fixed priority (MSB wins), 1 = round-robin.
- req  input  N  request vector, level-sensitive.
- gnt  output  N  one-hot grant, registered.
- gnt_idx  output  IDX_W  binary index of granted requester, registered; 0 when no grant.
- gnt_valid  output  1  high while any grant is held, registered.

Behaviour:
- Reset (async, asserting immediately): gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE, ptr=0, hold_cnt=0. Reset mid-grant drops the grant at once.
- State machine:
  - IDLE: if en && |req, arbitrate, register the winner, go to GRANT. Latency is 1 clk edge from req to gnt.
  - GRANT: owner holds gnt while en && req[owner].
- Release: if req[owner]=0 at an edge, re-arbitrate over req in the same edge.
  - Winner exists: gnt switches directly, with no idle bubble.
  - No winner: gnt=0, go to IDLE.
- Disable: en=0 at any edge gives gnt=0 and IDLE; ptr and hold_cnt are cleared to 0 only by rst.
- Fixed mode: winner is the highest set index of req.
- Round-robin mode: search order starts at ptr-1 and descends, wrapping N-1 ... ptr (ptr checked last).
  - ptr updates to the winner index on every grant, in both modes.
  - ptr=0 after reset, so the first round-robin search equals fixed priority.
- hold_cnt: cleared to 0 on every new grant; increments each cycle in GRANT.
- Timeout (MAX_HOLD>0): at the edge where hold_cnt==MAX_HOLD-1 and owner still requests, re-arbitrate with req[owner] masked.
  - Another requester wins: switch to it.
  - No other requester: owner keeps gnt, hold_cnt restarts at 0, and gnt_valid stays high without a gap.
  - Owner therefore holds at most MAX_HOLD consecutive cycles while others wait.
- Mode changes take effect at the next arbitration event only; a held grant is not disturbed.
- Output invariants: gnt is always zero or one-hot, and gnt_idx and gnt_valid are always consistent with gnt.
- Requests asserting while another grant is held are only considered at release or timeout. No request is latched; a requester that drops req before being granted is forgotten.

Test Plan:
- Reset: assert rst mid-grant with req=8'hFF. gnt=0, gnt_idx=0, gnt_valid=0 immediately, without waiting for an edge. After release, the first grant goes to idx 7.
- Fixed, back-to-back (N=8, MAX_HOLD=0, mode=0): req=8'b0010_0110 gives gnt=8'h20, idx=5 after 1 edge. Clear req[5] to get gnt=8'h04, idx=2 at the next edge, with no zero cycle between.
- Round-robin rotation (MAX_HOLD=4, mode=1): req=8'hFF held gives idx 7,6,5,4,3,2,1,0,7, each for exactly 4 cycles, with gnt_valid continuously high.
- Fixed timeout (MAX_HOLD=4, mode=0): req=8'hFF gives idx 7 for 4 cycles, then 6 for 4 cycles, then 7 again (alternating 7/6).
- Lone requester timeout (MAX_HOLD=4): req=8'h01 keeps gnt=8'h01 and gnt_valid high indefinitely, with no drop at timeout edges.
- Disable and mode switch:
  - Drop en during a grant: gnt=0 at the next edge; raising en re-arbitrates with latency 1.
  - Toggle mode during a held grant: grant is unchanged until release.

Source files
------------

// File: rtl/pri_arb_rr.sv
// pri_arb_rr: registered N-input arbiter with fixed-priority or round-robin
// selection. A grant is held while its owner keeps requesting. A hold-timeout
// forces re-arbitration so that one requester cannot starve the others.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   en        in   arbiter enable; low forces no grant
//   mode      in   0 = fixed priority (highest index wins), 1 = round-robin
//   req       in   [N-1:0] level-sensitive request vector
//   gnt       out  [N-1:0] one-hot grant, registered
//   gnt_idx   out  [IDX_W-1:0] binary index of the granted requester, 0 if none
//   gnt_valid out  high while any grant is held
module pri_arb_rr #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // hold_cnt only needs to reach MAX_HOLD-1.
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic [IDX_W:0]    full_res;
    logic [IDX_W:0]    mask_res;
    logic              owner_req;
    logic              timeout;
    logic              take;
    logic [IDX_W-1:0]  take_idx;
    logic              drop;
    logic              restart;

    // Returns {found, index}. Round-robin searches ptr-1 downwards, wrapping
    // through N-1, and checks ptr itself last; with ptr=0 this is the same
    // order as fixed priority.
    function automatic logic [IDX_W:0] arbitrate(input logic [N-1:0]     r,
                                                 input logic             rr,
                                                 input logic [IDX_W-1:0] p);
        logic             found;
        logic [IDX_W-1:0] win;
        int               c;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (rr) c = (int'(p) + 2 * N - 1 - k) % N;
            else    c = N - 1 - k;
            if (!found && r[c]) begin
                found = 1'b1;
                win   = IDX_W'(c);
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        full_res  = arbitrate(req, mode, ptr);
        // At timeout the current owner is excluded; gnt is its one-hot mask.
        mask_res  = arbitrate(req & ~gnt, mode, ptr);
        owner_req = |(req & gnt);
        timeout   = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
    end

    always_comb begin
        take     = 1'b0;
        take_idx = '0;
        drop     = 1'b0;
        restart  = 1'b0;
        case (state)
            IDLE: begin
                if (en && full_res[IDX_W]) begin
                    take     = 1'b1;
                    take_idx = full_res[IDX_W-1:0];
                end
            end
            GRANT: begin
                if (!en) begin
                    drop = 1'b1;
                end else if (!owner_req) begin
                    // Release: switch directly to a new winner, no idle bubble.
                    if (full_res[IDX_W]) begin
                        take     = 1'b1;
                        take_idx = full_res[IDX_W-1:0];
                    end else begin
                        drop = 1'b1;
                    end
                end else if (timeout) begin
                    if (mask_res[IDX_W]) begin
                        take     = 1'b1;
                        take_idx = mask_res[IDX_W-1:0];
                    end else begin
                        // Nobody else wants it: owner keeps the grant seamlessly.
                        restart = 1'b1;
                    end
                end
            end
            default: drop = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else if (take) begin
            state     <= GRANT;
            gnt       <= {{(N-1){1'b0}}, 1'b1} << take_idx;
            gnt_idx   <= take_idx;
            gnt_valid <= 1'b1;
            ptr       <= take_idx;
            hold_cnt  <= '0;
        end else if (drop) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (restart) begin
            hold_cnt  <= '0;
        end else if (state == GRANT) begin
            hold_cnt  <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pri_arb_rr.sv
// tb_pri_arb_rr: drives two pri_arb_rr instances (N=8; MAX_HOLD=4 and
// MAX_HOLD=0) from shared inputs. A reference model predicts the owner of
// each instance per cycle and queues it; a monitor pops and compares after
// every rising edge. Directed sequences add explicit expected values.
module tb_pri_arb_rr;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic [7:0] gnt0, gnt1;
    logic [2:0] idx0, idx1;
    logic       v0, v1;

    int checks = 0;
    int errors = 0;

    pri_arb_rr #(.N(8), .MAX_HOLD(4)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(v0)
    );

    pri_arb_rr #(.N(8), .MAX_HOLD(0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int o0;
        int o1;
    } exp_t;

    exp_t q[$];
    int   own [2];
    int   rptr[2];
    int   hold[2];
    int   lim [2] = '{4, 0};

    // Builds the priority order as a list and takes the first requester in it.
    function automatic int pick(input logic [7:0] r, input logic rr, input int p);
        int order[$];
        if (!rr) begin
            for (int i = 7; i >= 0; i--) order.push_back(i);
        end else begin
            for (int k = 1; k <= 8; k++) order.push_back((p - k + 8) % 8);
        end
        foreach (order[i]) if (r[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            own[d]  = -1;
            rptr[d] = 0;
            hold[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input logic e, input logic md, input logic [7:0] r);
        int w;
        if (!e) begin
            own[d] = -1;
        end else if (own[d] < 0 || !r[own[d]]) begin
            w = pick(r, md, rptr[d]);
            own[d] = w;
            if (w >= 0) begin
                rptr[d] = w;
                hold[d] = 0;
            end
        end else if (lim[d] > 0 && hold[d] == lim[d] - 1) begin
            logic [7:0] masked;
            masked = r;
            masked[own[d]] = 1'b0;
            w = pick(masked, md, rptr[d]);
            if (w >= 0) begin
                own[d]  = w;
                rptr[d] = w;
            end
            hold[d] = 0;
        end else begin
            hold[d]++;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic sb_cmp(input int d, input int o, input logic [7:0] g,
                          input logic [2:0] ix, input logic vl);
        logic [7:0] eg;
        int         ei;
        logic       ev;
        eg = (o < 0) ? 8'h00 : (8'h01 << o);
        ei = (o < 0) ? 0 : o;
        ev = (o >= 0);
        checks++;
        if (g !== eg || int'(ix) != ei || vl !== ev) begin
            errors++;
            $display("FAIL sb_dut%0d gnt=%h idx=%0d vld=%b expected gnt=%h idx=%0d vld=%b at %0t",
                     d, g, ix, vl, eg, ei, ev, $time);
        end
    endtask

    // Monitor: outputs are registered, so each edge presents one response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                sb_cmp(0, e.o0, gnt0, idx0, v0);
                sb_cmp(1, e.o1, gnt1, idx1, v1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic md, input logic [7:0] r);
        exp_t x;
        en   = e;
        mode = md;
        req  = r;
        model_step(0, e, md, r);
        model_step(1, e, md, r);
        x.o0 = own[0];
        x.o1 = own[1];
        q.push_back(x);
    endtask

    task automatic cyc(input logic e, input logic md, input logic [7:0] r);
        wait_neg();
        drive(e, md, r);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rr_req;
        logic       rr_mode;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        req  = 8'h00;
        model_reset();
        repeat (3) wait_neg();
        chk("reset_gnt", int'(gnt0), 0);
        chk("reset_idx", int'(idx0), 0);
        chk("reset_vld", int'(v0), 0);
        rst = 1'b0;

        // Round-robin rotation with MAX_HOLD=4: 7,6,...,0,7, 4 cycles each.
        drive(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 36; i++) begin
            wait_neg();
            chk("rr_idx", int'(idx0), (7 - i / 4 + 16) % 8);
            chk("rr_vld", int'(v0), 1);
            drive(1'b1, 1'b1, 8'hFF);
        end

        // Fixed priority timeout: alternates 7 and 6.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 16; i++) begin
            wait_neg();
            chk("fix_to_idx", int'(idx0), ((i / 4) % 2 == 1) ? 6 : 7);
            drive(1'b1, 1'b0, 8'hFF);
        end

        // Fixed back-to-back switch without a bubble (no timeout instance).
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h26);
        wait_neg();
        chk("b2b_gnt_a", int'(gnt1), 'h20);
        chk("b2b_idx_a", int'(idx1), 5);
        drive(1'b1, 1'b0, 8'h06);
        wait_neg();
        chk("b2b_gnt_b", int'(gnt1), 'h04);
        chk("b2b_idx_b", int'(idx1), 2);
        chk("b2b_vld_b", int'(v1), 1);
        drive(1'b1, 1'b0, 8'h06);

        // Lone requester: timeout never drops the grant.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 12; i++) begin
            wait_neg();
            chk("lone_gnt", int'(gnt0), 'h01);
            chk("lone_vld", int'(v0), 1);
            drive(1'b1, 1'b1, 8'h01);
        end

        // Disable during a grant, then re-enable.
        cyc(1'b1, 1'b0, 8'h30);
        wait_neg();
        chk("dis_pre", int'(gnt0), 'h20);
        drive(1'b0, 1'b0, 8'h30);
        wait_neg();
        chk("dis_gnt", int'(gnt0), 0);
        chk("dis_vld", int'(v0), 0);
        drive(1'b1, 1'b0, 8'h30);
        wait_neg();
        chk("reen_gnt", int'(gnt0), 'h20);
        drive(1'b1, 1'b0, 8'h30);

        // Mode toggle while a grant is held.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h81);
        for (int i = 0; i < 4; i++) begin
            wait_neg();
            chk("mode_hold", int'(gnt1), 'h80);
            drive(1'b1, 1'b1, 8'h81);
        end
        cyc(1'b1, 1'b1, 8'h01);

        // Asynchronous reset mid-grant.
        cyc(1'b1, 1'b0, 8'hFF);
        wait_neg();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gnt0", int'(gnt0), 0);
        chk("arst_idx0", int'(idx0), 0);
        chk("arst_vld0", int'(v0), 0);
        chk("arst_gnt1", int'(gnt1), 0);
        q.delete();
        model_reset();
        wait_neg();
        wait_neg();
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'hFF);
        wait_neg();
        chk("post_rst_idx", int'(idx0), 7);
        chk("post_rst_vld", int'(v0), 1);
        drive(1'b1, 1'b1, 8'hFF);

        // Randomized traffic.
        rr_req  = 8'h00;
        rr_mode = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) rr_mode = ~rr_mode;
            if ($urandom_range(0, 3) == 0) rr_req = 8'($urandom);
            else if ($urandom_range(0, 3) == 0) rr_req = rr_req & 8'($urandom);
            cyc($urandom_range(0, 15) != 0, rr_mode, rr_req);
        end

        wait_neg();
        wait_neg();
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
